// File: rtl/burst_sched_pkg.sv
// Shared widths, burst entry layout and slot arithmetic for the burst scheduler.
// The burst entry is {last, addr}; the main entry is {virt, addr}.
package burst_sched_pkg;

    localparam int DROP_CNT_W = 16;

    localparam int DEF_PRIO_NUM    = 57;
    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_VIRT_W      = 5;
    localparam int DEF_SPKREF_W    = 3;
    localparam int DEF_ISI_W       = 3;
    localparam int DEF_MAIN_DEPTH  = 32;
    localparam int DEF_BURST_DEPTH = 4;
    localparam int DEF_TIMEREF_W   = 20;

    function automatic int burst_w(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int main_w(input int addr_w, input int virt_w);
        return addr_w + virt_w;
    endfunction

    // The farthest burst target must never wrap back onto the current slot.
    function automatic bit burst_cfg_ok(input int prio_num,
                                        input int spkref_w,
                                        input int isi_w);
        return prio_num > ((1 << spkref_w) - 1) * (1 << isi_w);
    endfunction

    function automatic int slot_idx(input int ptr, input int k,
                                    input int isi, input int prio_num);
        return (ptr + k * (isi + 1)) % prio_num;
    endfunction

endpackage

// File: rtl/burst_scheduler_gen_fifo.sv
// Show-ahead synchronous FIFO with active-high clear and occupancy output.
// A push while full is discarded even if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             is_full;
    logic             is_empty;
    logic             do_push;
    logic             do_pop;

    assign count    = wr_ptr - rd_ptr;
    assign is_empty = (count == '0);
    assign is_full  = (count == (AW+1)'(DEPTH));
    assign do_push  = push & ~is_full;
    assign do_pop   = pop & ~is_empty;
    assign dout     = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/burst_scheduler_gen.sv
// Spike scheduler: main FIFO for immediate events plus a ring of burst slot
// FIFOs replayed one slot per tick period, with drop accounting.
module burst_scheduler_gen
    import burst_sched_pkg::*;
#(
    parameter int PRIO_NUM    = DEF_PRIO_NUM,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int VIRT_W      = DEF_VIRT_W,
    parameter int SPKREF_W    = DEF_SPKREF_W,
    parameter int ISI_W       = DEF_ISI_W,
    parameter int MAIN_DEPTH  = DEF_MAIN_DEPTH,
    parameter int BURST_DEPTH = DEF_BURST_DEPTH,
    parameter int TIMEREF_W   = DEF_TIMEREF_W
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              CTRL_EVT_VALID,
    input  logic [ADDR_W-1:0]                 CTRL_EVT_ADDR,
    input  logic [VIRT_W-1:0]                 CTRL_EVT_VIRT,
    input  logic [SPKREF_W-1:0]               CTRL_EVT_SPKREF,
    input  logic [ISI_W-1:0]                  CTRL_EVT_ISI,
    input  logic                              NEUR_EVT_VALID,
    input  logic [ADDR_W-1:0]                 NEUR_EVT_ADDR,
    input  logic [SPKREF_W-1:0]               NEUR_EVT_SPKREF,
    input  logic [ISI_W-1:0]                  NEUR_EVT_ISI,
    input  logic                              SPI_OPEN_LOOP,
    input  logic [TIMEREF_W-1:0]              SPI_BURST_TIMEREF,
    input  logic                              SPI_FLUSH_LATE,
    input  logic                              SCHED_POP,
    output logic                              SCHED_EMPTY,
    output logic                              SCHED_FULL,
    output logic                              SCHED_BURST_END,
    output logic [VIRT_W+ADDR_W-1:0]          SCHED_DATA_OUT,
    output logic [$clog2(PRIO_NUM)-1:0]       SCHED_PTR,
    output logic [DROP_CNT_W-1:0]             SCHED_DROP_CNT,
    output logic                              SCHED_OVF
);

    localparam int PTR_W  = $clog2(PRIO_NUM);
    localparam int DATA_W = main_w(ADDR_W, VIRT_W);
    localparam int BW     = burst_w(ADDR_W);
    localparam int MCW    = $clog2(MAIN_DEPTH) + 1;
    localparam int SCW    = $clog2(BURST_DEPTH) + 1;
    localparam int MAX_K  = (1 << SPKREF_W) - 1;

    if (!burst_cfg_ok(PRIO_NUM, SPKREF_W, ISI_W)) begin : g_cfg_err
        $error("burst_scheduler_gen: PRIO_NUM too small for SPKREF_W/ISI_W");
    end

    logic                  ol_q;
    logic                  ol_s;
    logic                  bursts_off;
    logic                  advance;
    logic [TIMEREF_W-1:0]  tick;
    logic [PTR_W-1:0]      ptr;

    logic                  sel_valid;
    logic [ADDR_W-1:0]     sel_addr;
    logic [VIRT_W-1:0]     sel_virt;
    logic [SPKREF_W-1:0]   sel_spk;
    logic [ISI_W-1:0]      sel_isi;

    logic                  main_push;
    logic                  main_pop;
    logic                  main_full;
    logic                  main_empty;
    logic [DATA_W-1:0]     main_din;
    logic [DATA_W-1:0]     main_dout;
    logic [MCW-1:0]        main_cnt;

    logic [PRIO_NUM-1:0]   slot_push;
    logic [PRIO_NUM-1:0]   slot_pop;
    logic [PRIO_NUM-1:0]   slot_clr;
    logic [PRIO_NUM-1:0]   slot_full;
    logic [PRIO_NUM-1:0]   slot_empty;
    logic [BW-1:0]         slot_din  [PRIO_NUM];
    logic [BW-1:0]         slot_dout [PRIO_NUM];
    logic [SCW-1:0]        slot_cnt  [PRIO_NUM];

    logic                  cur_empty;
    logic [BW-1:0]         cur_head;
    logic [SCW-1:0]        cur_cnt;
    logic                  pop_ok;
    logic                  cur_popped;
    logic                  flushing;

    logic [7:0]            push_drops;
    logic [SCW-1:0]        flush_drops;
    logic [DROP_CNT_W:0]   drop_sum;

    // Open-loop arrives from the SPI clock domain.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ol_q <= 1'b0;
            ol_s <= 1'b0;
        end else begin
            ol_q <= SPI_OPEN_LOOP;
            ol_s <= ol_q;
        end
    end

    assign bursts_off = ol_s | (SPI_BURST_TIMEREF == '0);
    assign advance    = ~bursts_off & (tick == SPI_BURST_TIMEREF);
    assign flushing   = advance & SPI_FLUSH_LATE;

    always_ff @(posedge CLK) begin
        if (RST || bursts_off) begin
            tick <= '0;
            ptr  <= '0;
        end else if (advance) begin
            tick <= '0;
            ptr  <= (ptr == PTR_W'(PRIO_NUM-1)) ? '0 : ptr + 1'b1;
        end else begin
            tick <= tick + 1'b1;
        end
    end

    assign SCHED_PTR = ptr;

    always_comb begin
        sel_valid = 1'b0;
        sel_addr  = '0;
        sel_virt  = '0;
        sel_spk   = '0;
        sel_isi   = '0;
        unique case (1'b1)
            CTRL_EVT_VALID: begin
                sel_valid = 1'b1;
                sel_addr  = CTRL_EVT_ADDR;
                sel_virt  = CTRL_EVT_VIRT;
                sel_spk   = CTRL_EVT_SPKREF;
                sel_isi   = CTRL_EVT_ISI;
            end
            NEUR_EVT_VALID & ~ol_s & ~CTRL_EVT_VALID: begin
                sel_valid = 1'b1;
                sel_addr  = NEUR_EVT_ADDR;
                sel_spk   = NEUR_EVT_SPKREF;
                sel_isi   = NEUR_EVT_ISI;
            end
            default: ;
        endcase
    end

    assign main_push = sel_valid & ((sel_spk == '0) | bursts_off);
    assign main_din  = {sel_virt, sel_addr};

    // Burst targets are distinct slots, so each slot sees at most one push.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx       = '0;
        slot_push = '0;
        for (int s = 0; s < PRIO_NUM; s++) slot_din[s] = '0;
        if (sel_valid && sel_spk != '0 && !bursts_off) begin
            for (int k = 1; k <= MAX_K; k++) begin
                if (k <= int'(sel_spk)) begin
                    idx = PTR_W'(slot_idx(int'(ptr), k, int'(sel_isi),
                                          PRIO_NUM));
                    slot_push[idx] = 1'b1;
                    slot_din[idx]  = {k == int'(sel_spk), sel_addr};
                end
            end
        end
    end

    assign cur_empty  = slot_empty[ptr];
    assign cur_head   = slot_dout[ptr];
    assign cur_cnt    = slot_cnt[ptr];
    assign main_empty = (main_cnt == '0);
    assign main_full  = (main_cnt == MCW'(MAIN_DEPTH));

    assign SCHED_EMPTY = main_empty & cur_empty;
    assign SCHED_FULL  = main_full;
    assign pop_ok      = SCHED_POP & ~SCHED_EMPTY;
    assign cur_popped  = pop_ok & ~cur_empty;
    assign main_pop    = pop_ok & cur_empty;

    always_comb begin
        slot_pop      = '0;
        slot_pop[ptr] = cur_popped;
        slot_clr      = {PRIO_NUM{bursts_off}};
        slot_clr[ptr] = bursts_off | flushing;
    end

    always_comb begin
        SCHED_DATA_OUT  = '0;
        SCHED_BURST_END = 1'b0;
        unique case (1'b1)
            !cur_empty: begin
                SCHED_DATA_OUT  = {VIRT_W'(0), cur_head[ADDR_W-1:0]};
                SCHED_BURST_END = cur_head[ADDR_W];
            end
            !main_empty & cur_empty: SCHED_DATA_OUT = main_dout;
            default: ;
        endcase
    end

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(MAIN_DEPTH)) u_main (
        .clk   (CLK),
        .rst   (RST),
        .clr   (1'b0),
        .push  (main_push),
        .pop   (main_pop),
        .din   (main_din),
        .dout  (main_dout),
        .count (main_cnt)
    );

    for (genvar s = 0; s < PRIO_NUM; s++) begin : g_slot
        sync_fifo #(.WIDTH(BW), .DEPTH(BURST_DEPTH)) u_slot (
            .clk   (CLK),
            .rst   (RST),
            .clr   (slot_clr[s]),
            .push  (slot_push[s]),
            .pop   (slot_pop[s]),
            .din   (slot_din[s]),
            .dout  (slot_dout[s]),
            .count (slot_cnt[s])
        );
        assign slot_empty[s] = (slot_cnt[s] == '0);
        assign slot_full[s]  = (slot_cnt[s] == SCW'(BURST_DEPTH));
    end

    // A flush only discards what the same-cycle pop leaves behind.
    always_comb begin
        push_drops = 8'(main_push & main_full);
        for (int s = 0; s < PRIO_NUM; s++) begin
            push_drops = push_drops + 8'(slot_push[s] & slot_full[s]);
        end
        flush_drops = flushing ? cur_cnt - SCW'(cur_popped) : '0;
        drop_sum    = (DROP_CNT_W+1)'(SCHED_DROP_CNT)
                    + (DROP_CNT_W+1)'(push_drops)
                    + (DROP_CNT_W+1)'(flush_drops);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            SCHED_DROP_CNT <= '0;
            SCHED_OVF      <= 1'b0;
        end else if (push_drops != '0 || flush_drops != '0) begin
            SCHED_DROP_CNT <= drop_sum[DROP_CNT_W] ? '1
                                                   : drop_sum[DROP_CNT_W-1:0];
            SCHED_OVF      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_burst_scheduler_gen.sv
// Directed and randomized bench for burst_scheduler_gen against a queue model.
// Model outputs are compared with the DUT after every clock edge.
module tb_burst_scheduler_gen;

    logic        clk;
    logic        rst;
    logic        ctrl_valid;
    logic [7:0]  ctrl_addr;
    logic [4:0]  ctrl_virt;
    logic [2:0]  ctrl_spk;
    logic [2:0]  ctrl_isi;
    logic        neur_valid;
    logic [7:0]  neur_addr;
    logic [2:0]  neur_spk;
    logic [2:0]  neur_isi;
    logic        open_loop;
    logic [19:0] timeref;
    logic        flush;
    logic        pop;
    logic        empty;
    logic        full;
    logic        burst_end;
    logic [12:0] data;
    logic [5:0]  ptr;
    logic [15:0] drop_cnt;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    logic [12:0] m_main [$];
    logic [8:0]  m_slot [57][$];
    int          m_ptr;
    int          m_tick;
    int          m_drop;
    bit          m_ovf;
    bit          m_ol1;
    bit          m_ol2;

    burst_scheduler_gen dut (
        .CLK               (clk),
        .RST               (rst),
        .CTRL_EVT_VALID    (ctrl_valid),
        .CTRL_EVT_ADDR     (ctrl_addr),
        .CTRL_EVT_VIRT     (ctrl_virt),
        .CTRL_EVT_SPKREF   (ctrl_spk),
        .CTRL_EVT_ISI      (ctrl_isi),
        .NEUR_EVT_VALID    (neur_valid),
        .NEUR_EVT_ADDR     (neur_addr),
        .NEUR_EVT_SPKREF   (neur_spk),
        .NEUR_EVT_ISI      (neur_isi),
        .SPI_OPEN_LOOP     (open_loop),
        .SPI_BURST_TIMEREF (timeref),
        .SPI_FLUSH_LATE    (flush),
        .SCHED_POP         (pop),
        .SCHED_EMPTY       (empty),
        .SCHED_FULL        (full),
        .SCHED_BURST_END   (burst_end),
        .SCHED_DATA_OUT    (data),
        .SCHED_PTR         (ptr),
        .SCHED_DROP_CNT    (drop_cnt),
        .SCHED_OVF         (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit          boff;
        bit          mfull;
        bit          have;
        int          n;
        int          idx;
        logic [7:0]  a;
        logic [4:0]  v;
        int          sp;
        int          is;
        if (rst) begin
            m_main.delete();
            for (int i = 0; i < 57; i++) m_slot[i].delete();
            m_ptr = 0; m_tick = 0; m_drop = 0;
            m_ovf = 0; m_ol1 = 0; m_ol2 = 0;
            return;
        end
        boff  = m_ol2 || (timeref == 20'd0);
        mfull = (m_main.size() == 32);
        n     = 0;
        if (pop) begin
            if (m_slot[m_ptr].size() != 0) m_slot[m_ptr].delete(0);
            else if (m_main.size() != 0) m_main.delete(0);
        end
        have = 1'b0; a = '0; v = '0; sp = 0; is = 0;
        if (ctrl_valid) begin
            have = 1; a = ctrl_addr; v = ctrl_virt;
            sp = int'(ctrl_spk); is = int'(ctrl_isi);
        end else if (neur_valid && !m_ol2) begin
            have = 1; a = neur_addr;
            sp = int'(neur_spk); is = int'(neur_isi);
        end
        if (have) begin
            if (sp == 0 || boff) begin
                if (mfull) n++;
                else m_main.push_back({v, a});
            end else begin
                for (int k = 1; k <= sp; k++) begin
                    idx = (m_ptr + k * (is + 1)) % 57;
                    if (m_slot[idx].size() == 4) n++;
                    else m_slot[idx].push_back({k == sp, a});
                end
            end
        end
        if (boff) begin
            for (int i = 0; i < 57; i++) m_slot[i].delete();
            m_ptr = 0; m_tick = 0;
        end else if (m_tick == int'(timeref)) begin
            if (flush) begin
                n += m_slot[m_ptr].size();
                m_slot[m_ptr].delete();
            end
            m_ptr  = (m_ptr + 1) % 57;
            m_tick = 0;
        end else begin
            m_tick++;
        end
        if (n > 0) begin
            m_drop = (m_drop + n > 65535) ? 65535 : m_drop + n;
            m_ovf  = 1;
        end
        m_ol2 = m_ol1;
        m_ol1 = open_loop;
    endtask

    task automatic compare_all();
        logic [12:0] ed;
        logic [8:0]  h;
        bit          ebe;
        bit          ee;
        ed  = '0;
        ebe = 0;
        ee  = (m_main.size() == 0) && (m_slot[m_ptr].size() == 0);
        if (m_slot[m_ptr].size() != 0) begin
            h   = m_slot[m_ptr][0];
            ed  = {5'd0, h[7:0]};
            ebe = h[8];
        end else if (m_main.size() != 0) begin
            ed = m_main[0];
        end
        chk("m_empty", 32'(empty), 32'(ee));
        chk("m_full", 32'(full), 32'(m_main.size() == 32));
        chk("m_data", 32'(data), 32'(ed));
        chk("m_burst_end", 32'(burst_end), 32'(ebe));
        chk("m_ptr", 32'(ptr), 32'(m_ptr));
        chk("m_drop", 32'(drop_cnt), 32'(m_drop));
        chk("m_ovf", 32'(ovf), 32'(m_ovf));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_ptr(input int target, input int budget);
        for (int n = 0; n < budget && int'(ptr) != target; n++) step();
        chk("wait_ptr", 32'(ptr), 32'(target));
    endtask

    task automatic push_ctrl(input logic [7:0] a, input logic [4:0] v,
                             input logic [2:0] s, input logic [2:0] i);
        ctrl_valid = 1'b1;
        ctrl_addr  = a;
        ctrl_virt  = v;
        ctrl_spk   = s;
        ctrl_isi   = i;
        step();
        ctrl_valid = 1'b0;
    endtask

    initial begin
        int pop_pct;
        rst = 1'b1; ctrl_valid = 0; ctrl_addr = 0; ctrl_virt = 0;
        ctrl_spk = 0; ctrl_isi = 0; neur_valid = 0; neur_addr = 0;
        neur_spk = 0; neur_isi = 0; open_loop = 0; timeref = 20'd3;
        flush = 0; pop = 0;
        #1;
        step();
        step();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        rst = 1'b0;

        neur_valid = 1; neur_addr = 8'h12; neur_spk = 0;
        step();
        neur_valid = 0;
        chk("neur_empty", 32'(empty), 32'd0);
        chk("neur_data", 32'(data), 32'h012);
        pop = 1;
        step();
        pop = 0;
        chk("neur_pop_empty", 32'(empty), 32'd1);

        do_reset();
        push_ctrl(8'h40, 5'd3, 3'd3, 3'd1);
        chk("burst_not_main", 32'(empty), 32'd1);
        wait_ptr(2, 50);
        chk("slot2_data", 32'(data), 32'h040);
        chk("slot2_end", 32'(burst_end), 32'd0);
        wait_ptr(4, 50);
        chk("slot4_end", 32'(burst_end), 32'd0);
        wait_ptr(6, 50);
        chk("slot6_data", 32'(data), 32'h040);
        chk("slot6_end", 32'(burst_end), 32'd1);

        do_reset();
        timeref = 20'd0;
        neur_valid = 1; neur_spk = 0;
        for (int i = 0; i < 33; i++) begin
            neur_addr = 8'(i);
            step();
        end
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_drop1", 32'(drop_cnt), 32'd1);
        chk("ovf_sticky", 32'(ovf), 32'd1);
        pop = 1;
        step();
        pop = 0; neur_valid = 0;
        chk("ovf_pop_drop2", 32'(drop_cnt), 32'd2);
        chk("ovf_pop_head", 32'(data), 32'h001);
        timeref = 20'd3;

        flush = 1;
        do_reset();
        push_ctrl(8'h40, 5'd0, 3'd1, 3'd1);
        push_ctrl(8'h40, 5'd0, 3'd1, 3'd1);
        wait_ptr(2, 50);
        chk("flush_slot2", 32'(data), 32'h040);
        wait_ptr(3, 50);
        chk("flush_drop", 32'(drop_cnt), 32'd2);

        flush = 0;
        do_reset();
        push_ctrl(8'h40, 5'd0, 3'd1, 3'd1);
        push_ctrl(8'h40, 5'd0, 3'd1, 3'd1);
        wait_ptr(3, 50);
        chk("keep_drop", 32'(drop_cnt), 32'd0);
        chk("keep_empty", 32'(empty), 32'd1);
        wait_ptr(2, 300);
        chk("keep_revisit", 32'(data), 32'h040);

        do_reset();
        push_ctrl(8'h40, 5'd0, 3'd3, 3'd1);
        wait_ptr(2, 50);
        open_loop = 1;
        step(); step(); step();
        chk("ol_ptr", 32'(ptr), 32'd0);
        chk("ol_empty", 32'(empty), 32'd1);
        neur_valid = 1; neur_spk = 0;
        step();
        neur_valid = 0;
        chk("ol_neur_ignored", 32'(empty), 32'd1);
        push_ctrl(8'h55, 5'h0a, 3'd3, 3'd1);
        chk("ol_ctrl_main", 32'(data), 32'hA55);
        open_loop = 0;

        do_reset();
        ctrl_valid = 1; ctrl_addr = 8'h21; ctrl_virt = 5'd1; ctrl_spk = 0;
        neur_valid = 1; neur_addr = 8'h33; neur_spk = 0;
        step();
        ctrl_valid = 0; neur_valid = 0;
        chk("simul_ctrl", 32'(data), 32'h121);
        pop = 1;
        step();
        pop = 0;
        chk("simul_one", 32'(empty), 32'd1);
        for (int i = 0; i < 5; i++) push_ctrl(8'(i), 5'd0, 3'd0, 3'd0);
        do_reset();
        chk("rst_mid_empty", 32'(empty), 32'd1);
        chk("rst_mid_drop", 32'(drop_cnt), 32'd0);

        pop_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 400 == 0) begin
                timeref = 20'($urandom_range(0, 3));
                flush   = 1'($urandom_range(0, 1));
                pop_pct = ($urandom_range(0, 1) == 0) ? 25 : 80;
            end
            if (c % 150 == 0) open_loop = ($urandom_range(0, 3) == 0);
            rst        = ($urandom_range(0, 999) == 0);
            ctrl_valid = ($urandom_range(0, 3) == 0);
            ctrl_addr  = 8'($urandom);
            ctrl_virt  = 5'($urandom);
            ctrl_spk   = 3'($urandom);
            ctrl_isi   = 3'($urandom);
            neur_valid = ($urandom_range(0, 2) == 0);
            neur_addr  = 8'($urandom);
            neur_spk   = 3'($urandom);
            neur_isi   = 3'($urandom);
            pop        = ($urandom_range(0, 99) < pop_pct);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/burst_scheduler_gen.md
Name: burst_scheduler_gen

Overview:
- Parametrised next-generation spike scheduler between the neuron/controller event sources and the controller's event-processing loop.
- Holds a main FIFO for immediate events and a ring of PRIO_NUM burst slot FIFOs that replay spike bursts at ISI-spaced time slots.
- Adds over the previous generation:
  - generic widths and depths;
  - an explicit overflow/drop accounting path;
  - a configurable late-slot policy (keep or flush);
  - a single-cycle pop handshake.

Parameters:
- PRIO_NUM, 57: number of burst time slots in the ring.
- ADDR_W, 8: neuron address width.
- VIRT_W, 5: virtual-synapse tag width (main FIFO only).
- SPKREF_W, 3: burst spike-count field width; a burst holds up to 2^SPKREF_W-1 spikes.
- ISI_W, 3: ISI field width; spacing = isi+1 slots.
- MAIN_DEPTH, 32: main FIFO depth (power of 2).
- BURST_DEPTH, 4: per-slot FIFO depth (power of 2).
- TIMEREF_W, 20: slot-period counter width.
- Elaboration check: PRIO_NUM > (2^SPKREF_W-1)*2^ISI_W (default 56 < 57); otherwise $error.

Ports:
- CLK  in  1  clock; one clock domain.
- RST  in  1  reset; synchronous, active-high.
- CTRL_EVT_VALID  in  1  controller event strobe.
- CTRL_EVT_ADDR  in  ADDR_W  controller event address.
- CTRL_EVT_VIRT  in  VIRT_W  controller virtual tag.
- CTRL_EVT_SPKREF  in  SPKREF_W  controller burst spike count.
- CTRL_EVT_ISI  in  ISI_W  controller burst ISI.
- NEUR_EVT_VALID  in  1  neuron output spike strobe.
- NEUR_EVT_ADDR  in  ADDR_W  neuron event address.
- NEUR_EVT_SPKREF  in  SPKREF_W  neuron burst spike count.
- NEUR_EVT_ISI  in  ISI_W  neuron burst ISI.
- SPI_OPEN_LOOP  in  1  async config; blocks neuron events and disables bursts.
- SPI_BURST_TIMEREF  in  TIMEREF_W  slot period minus 1, in cycles; 0 = bursts disabled.
- SPI_FLUSH_LATE  in  1  1 = drop entries still in a slot when the pointer leaves it.
- SCHED_POP  in  1  consume head (active-high, one cycle).
- SCHED_EMPTY  out  1  no entry available.
- SCHED_FULL  out  1  main FIFO full.
- SCHED_BURST_END  out  1  head is the last spike of its burst.
- SCHED_DATA_OUT  out  VIRT_W+ADDR_W  head entry {virt,addr}; burst entries have virt=0.
- SCHED_PTR  out  $clog2(PRIO_NUM)  current slot pointer.
- SCHED_DROP_CNT  out  16  saturating count of dropped entries (push overflow and late flush).
- SCHED_OVF  out  1  sticky; set on any drop.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - all FIFOs empty, ptr=0, tick counter=0, DROP_CNT=0, OVF=0, sync flops=0.
  - Outputs: SCHED_EMPTY=1, SCHED_FULL=0, SCHED_BURST_END=0, SCHED_DATA_OUT=0.
  - Reset mid-operation discards all content and any same-cycle push/pop.
- SPI_OPEN_LOOP passes through a 2-flop synchroniser (ol_s).
- bursts_off = ol_s | (SPI_BURST_TIMEREF==0). While bursts_off: ptr, tick counter and all slot FIFOs are held cleared every cycle.
- Source select:
  - Controller event wins when CTRL_EVT_VALID=1.
  - Otherwise a neuron event if NEUR_EVT_VALID & ~ol_s.
  - A simultaneous neuron event is lost and is not counted.
- Push routing:
  - spkref==0 or bursts_off: one push to main FIFO of {virt,addr}. Neuron events use virt=0; controller bursts routed to main keep CTRL_EVT_VIRT.
  - Else, for k=1..spkref: push {last=(k==spkref), addr} into slot (ptr + k*(isi+1)) mod PRIO_NUM, all in the same cycle. The target is never the current slot (guaranteed by the elaboration check).
- Overflow:
  - A push to a FIFO that is full at the start of the cycle is dropped, even with a simultaneous pop.
  - Each dropped entry increments DROP_CNT; several in one cycle add their count. DROP_CNT saturates at 0xFFFF. OVF is set.
- Slot timing:
  - tick counts 0..SPI_BURST_TIMEREF, then wraps to 0 and ptr advances by 1.
  - ptr wraps PRIO_NUM-1 -> 0.
  - If TIMEREF is lowered below the current tick, the next compare-equal occurs after counter wrap at 2^TIMEREF_W. This is accepted behaviour.
- Late policy, on a ptr advance:
  - SPI_FLUSH_LATE=1: the slot being left is cleared and its occupancy is added to DROP_CNT.
  - SPI_FLUSH_LATE=0: entries remain and are served on the next visit.
- Output (show-ahead, combinational from FIFO heads):
  - When current slot is non-empty: DATA_OUT={0,addr}, BURST_END=last bit.
  - Otherwise main head is output with BURST_END=0.
  - SCHED_EMPTY = main empty & current slot empty.
- Pop:
  - SCHED_POP with SCHED_EMPTY=0 removes the selected head (slot before main).
  - Pop while empty is ignored.
  - A pushed entry is visible at the next cycle (latency 1).
  - A pop coinciding with ptr advance or flush pops the pre-advance head; the flush applies to the remaining entries.

Decomposition:
- Package burst_sched_pkg: payload widths, burst entry layout {last,addr}, DROP_CNT_W=16, the elaboration-check function, and a slot-index function (ptr + k*(isi+1)) mod PRIO_NUM.
- Sub-module sync_fifo (WIDTH, DEPTH; sync active-high clear; show-ahead; occupancy output). Instantiated once for main and PRIO_NUM times for slots.

Test Plan:
- Reset, then neuron event addr=0x12, spkref=0 -> next cycle EMPTY=0, DATA_OUT=0x012; POP -> EMPTY=1.
- TIMEREF=3, ctrl event addr=0x40, spkref=3, isi=1 at ptr=0 -> slots 2,4,6 filled. Head appears at cycles 8,16,24 after the push; BURST_END=1 only on slot 6.
- Push 33 events with no pop -> FULL=1 after 32, DROP_CNT=1, OVF=1. Repeat with pop in the same cycle while full -> still dropped.
- Fill slot 2 with 2 entries, no pop, FLUSH_LATE=1 -> on ptr 2->3, DROP_CNT+=2. With FLUSH_LATE=0 -> entries reappear after 57*(TIMEREF+1) cycles.
- Set SPI_OPEN_LOOP=1 mid-burst -> 2 cycles later ptr=0 and all slots empty; NEUR_EVT_VALID ignored; controller events go to main.
- Simultaneous CTRL and NEUR valid -> only the controller event is stored. RST asserted with 5 entries queued -> EMPTY=1, DROP_CNT=0.
